pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the single-channel 8-bit PWM. One shared period counter drives `CHANNELS` comparators with configurable resolution. Each channel has a shadow duty register, so a duty change takes effect only at a period boundary and never produces a glitched pulse. It sits between the controller's register/command logic and the motor/LED driver pins.

---
 rtl/pwm_multi_pkg.sv | 13 +
 rtl/pwm_multi_if.sv | 30 +++
 rtl/pwm_channel.sv | 38 +++
 rtl/pwm_multi.sv | 104 ++++++++++
 tb/tb_pwm_multi.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_multi_pkg.sv
// pwm_multi shared defaults and types.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter.
package pwm_multi_pkg;

  localparam int PWM_WIDTH    = 8;
  localparam int PWM_CHANNELS = 4;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Command/output bundle between the register logic and pwm_multi.
// master = controller side, slave = PWM block.
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);

  logic                        en;
  logic [CHANNELS*WIDTH-1:0]   duty;
  logic [CHANNELS-1:0]         duty_wr;
  logic [CHANNELS-1:0]         pwm_out;
  logic                        sync;

  modport master (
    output en,
    output duty,
    output duty_wr,
    input  pwm_out,
    input  sync
  );

  modport slave (
    input  en,
    input  duty,
    input  duty_wr,
    output pwm_out,
    output sync
  );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty pair and registered compare.
// A write in the boundary cycle goes straight into active.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             boundary,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  input  logic             wr,
  output logic             pwm_out
);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr)
        pending <= duty;
      // pending follows too, so the next boundary keeps the bypassed value
      if (boundary)
        active <= wr ? duty : pending;
      else if (!en)
        active <= pending;
      pwm_out <= en & (cnt < active);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, boundary and sync.
// PWM_CENTER_ALIGN_EN selects an up/down counter (valley reload).
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int CHANNELS = PWM_CHANNELS
) (
  input  logic        clk,
  input  logic        rst,
  pwm_multi_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    cnt_nx;
  logic                boundary;
  logic                sync_q;
  logic [CHANNELS-1:0] pwm;

`ifdef PWM_CENTER_ALIGN_EN
  dir_e dir;
  dir_e dir_nx;

  always_comb begin
    cnt_nx   = cnt;
    dir_nx   = dir;
    boundary = bus.en && (dir == DIR_DOWN) && (cnt == ONE);
    if (bus.en) begin
      unique case (dir)
        DIR_UP: begin
          if (cnt == CNT_MAX) begin
            dir_nx = DIR_DOWN;
            cnt_nx = cnt - ONE;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
        DIR_DOWN: begin
          if (cnt == '0) begin
            dir_nx = DIR_UP;
            cnt_nx = cnt + ONE;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_nx;
      dir <= dir_nx;
    end
  end
`else
  always_comb begin
    cnt_nx   = cnt;
    boundary = bus.en && (cnt == CNT_MAX);
    if (bus.en)
      cnt_nx = cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_nx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      sync_q <= 1'b0;
    else
      sync_q <= bus.en && (cnt == '0);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .boundary (boundary),
      .cnt      (cnt),
      .duty     (bus.duty[i*WIDTH +: WIDTH]),
      .wr       (bus.duty_wr[i]),
      .pwm_out  (pwm[i])
    );
  end

  assign bus.pwm_out = pwm;
  assign bus.sync    = sync_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (edge mode W=8, center mode W=4).
// Outputs are sampled 1 time unit after each rising edge.
module tb_pwm_multi;

`ifdef PWM_CENTER_ALIGN_EN
  localparam int W = 4;
`else
  localparam int W = 8;
`endif
  localparam int C = 4;
  localparam int P = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multi_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  pwm_multi #(
    .WIDTH    (W),
    .CHANNELS (C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst)
      m = 0;
    else if (bus.en)
      m = (m + 1) % P;
    #1;
  endtask

  task automatic set_duty(input int d0, input int d1,
                          input int d2, input int d3);
    bus.duty[0*W +: W] = W'(d0);
    bus.duty[1*W +: W] = W'(d1);
    bus.duty[2*W +: W] = W'(d2);
    bus.duty[3*W +: W] = W'(d3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

`ifndef PWM_CENTER_ALIGN_EN
  typedef struct {
    logic [C-1:0] wr;
    int           d[C];
    int           at;
    int           hi[C];
  } vec_t;

  function automatic vec_t mk(input logic [C-1:0] wr,
                              input int d0, input int d1,
                              input int d2, input int d3,
                              input int at,
                              input int h0, input int h1,
                              input int h2, input int h3);
    vec_t v;
    v.wr = wr;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.at = at;
    v.hi[0] = h0; v.hi[1] = h1; v.hi[2] = h2; v.hi[3] = h3;
    return v;
  endfunction

  // one full period starting at cnt=0, optional write at cnt=v.at
  task automatic run_period(input vec_t v, input int idx);
    int hi[C];
    int syncs = 0;
    int misal = 0;
    int first = 0;
    logic [C-1:0] prev;
    logic [C-1:0] rise;
    prev = bus.pwm_out;
    for (int c = 0; c < C; c++) hi[c] = 0;
    for (int k = 0; k < P; k++) begin
      if (k == v.at) begin
        bus.duty_wr = v.wr;
        set_duty(v.d[0], v.d[1], v.d[2], v.d[3]);
      end
      step();
      bus.duty_wr = '0;
      for (int c = 0; c < C; c++)
        if (bus.pwm_out[c]) hi[c]++;
      if (bus.sync) syncs++;
      if (k == 0) first = int'(bus.sync);
      rise = bus.pwm_out & ~prev;
      if (rise != '0 && !bus.sync) misal++;
      prev = bus.pwm_out;
    end
    for (int c = 0; c < C; c++)
      check($sformatf("vec%0d_hi_ch%0d", idx, c), hi[c], v.hi[c]);
    check($sformatf("vec%0d_sync_cnt", idx), syncs, 1);
    check($sformatf("vec%0d_sync_first", idx), first, 1);
    check($sformatf("vec%0d_edge_align", idx), misal, 0);
  endtask

  vec_t tv[9];

  initial begin
    int hi2, hi3, hi1, syncs, bad;
    tv[0] = mk(4'b0000,   0,  0,   0, 0,  -1,  64, 128, 192, 0);
    tv[1] = mk(4'b0001, 200,  0,   0, 0, 100,  64, 128, 192, 0);
    tv[2] = mk(4'b0000,   0,  0,   0, 0,  -1, 200, 128, 192, 0);
    tv[3] = mk(4'b0010,   0, 32,   0, 0, 255, 200, 128, 192, 0);
    tv[4] = mk(4'b0000,   0,  0,   0, 0,  -1, 200,  32, 192, 0);
    tv[5] = mk(4'b0101,   0,  0, 255, 0,  10, 200,  32, 192, 0);
    tv[6] = mk(4'b0000,   0,  0,   0, 0,  -1,   0,  32, 255, 0);
    tv[7] = mk(4'b1000,   0,  0,   0, 1,   0,   0,  32, 255, 0);
    tv[8] = mk(4'b0000,   0,  0,   0, 0,  -1,   0,  32, 255, 1);

    rst = 1'b1;
    bus.en = 1'b0;
    bus.duty = '0;
    bus.duty_wr = '0;
    step();
    step();
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_sync", int'(bus.sync), 0);

    rst = 1'b0;
    set_duty(64, 128, 192, 0);
    bus.duty_wr = 4'b1111;
    step();
    bus.duty_wr = '0;
    step();
    check("preload_pwm_idle", int'(bus.pwm_out), 0);

    bus.en = 1'b1;
    for (int i = 0; i < 9; i++)
      run_period(tv[i], i);

    // enable gap at cnt=50
    for (int k = 0; k < P && m != 50; k++) step();
    bus.en = 1'b0;
    step();
    check("en_off_pwm", int'(bus.pwm_out), 0);
    check("en_off_sync", int'(bus.sync), 0);
    bad = 0;
    for (int k = 0; k < 19; k++) begin
      step();
      if (bus.pwm_out != '0 || bus.sync) bad++;
    end
    check("en_off_hold", bad, 0);
    bus.en = 1'b1;
    hi1 = 0; hi2 = 0; hi3 = 0; syncs = 0;
    for (int k = 0; k < 206; k++) begin
      step();
      if (bus.pwm_out[1]) hi1++;
      if (bus.pwm_out[2]) hi2++;
      if (bus.pwm_out[3]) hi3++;
      if (bus.sync) syncs++;
    end
    check("resume_hi_ch1", hi1, 0);
    check("resume_hi_ch2", hi2, 205);
    check("resume_hi_ch3", hi3, 0);
    check("resume_no_sync", syncs, 0);
    step();
    check("resume_sync", int'(bus.sync), 1);
    check("resume_pwm", int'(bus.pwm_out), 4'b1110);

    // reset mid-period, with a colliding write
    for (int k = 0; k < P && m != 100; k++) step();
    rst = 1'b1;
    set_duty(170, 170, 170, 170);
    bus.duty_wr = 4'b1111;
    step();
    bus.duty_wr = '0;
    check("midrst_pwm", int'(bus.pwm_out), 0);
    check("midrst_sync", int'(bus.sync), 0);
    rst = 1'b0;
    step();
    check("restart_sync", int'(bus.sync), 1);
    check("restart_pwm", int'(bus.pwm_out), 0);
    bad = 0;
    for (int k = 0; k < 2 * P; k++) begin
      step();
      if (bus.pwm_out != '0) bad++;
    end
    check("rst_over_wr", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
`else
  initial begin
    int hi, syncs, first, s4, s5, s29;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.duty = '0;
    bus.duty_wr = '0;
    step();
    step();
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_sync", int'(bus.sync), 0);

    rst = 1'b0;
    set_duty(5, 0, 0, 0);
    bus.duty_wr = 4'b0001;
    step();
    bus.duty_wr = '0;
    step();
    check("preload_pwm_idle", int'(bus.pwm_out), 0);

    // up 0..15, down 14..1: 30 samples; duty 5 -> cnt 0..4 up + 4..1 down
    bus.en = 1'b1;
    hi = 0; syncs = 0; first = 0; s4 = 0; s5 = 0; s29 = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) begin
        set_duty(3, 0, 0, 0);
        bus.duty_wr = 4'b0001;
      end
      step();
      bus.duty_wr = '0;
      if (bus.pwm_out[0]) hi++;
      if (bus.sync) syncs++;
      if (k == 0) first = int'(bus.sync);
      if (k == 4) s4 = int'(bus.pwm_out[0]);
      if (k == 5) s5 = int'(bus.pwm_out[0]);
      if (k == 29) s29 = int'(bus.pwm_out[0]);
    end
    check("c_hi_d5", hi, 9);
    check("c_sync_cnt", syncs, 1);
    check("c_sync_first", first, 1);
    check("c_up_last_hi", s4, 1);
    check("c_up_first_lo", s5, 0);
    check("c_down_tail_hi", s29, 1);

    hi = 0; syncs = 0; first = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.pwm_out[0]) hi++;
      if (bus.sync) syncs++;
      if (k == 0) first = int'(bus.sync);
    end
    check("c_hi_d3", hi, 5);
    check("c_sync_cnt2", syncs, 1);
    check("c_sync_first2", first, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
`endif

endmodule
